// File: rtl/shift_register.sv
// Parameterised word register with parallel load, synchronous clear and
// 1-bit left/right shift; operand/accumulator stage of the mul/div datapath.
module shift_register #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_en,
    input  logic             shiftLeft,
    input  logic             shiftRight,
    input  logic             newBit,
    input  logic [width-1:0] parallelIn,
    output logic [width-1:0] parallelOut
);

    localparam int unsigned W = width;

    if (W < 2) begin : g_bad_width
        $error("shift_register: width must be >= 2");
    end

    logic [W-1:0] reg_q;
    logic [W-1:0] reg_d;

    // One action per edge: clear > load > left shift > right shift > hold.
    always_comb begin
        reg_d = reg_q;
        if (clear) begin
            reg_d = '0;
        end else if (sample_en) begin
            reg_d = parallelIn;
        end else if (shiftLeft) begin
            reg_d = {reg_q[W-2:0], newBit};
        end else if (shiftRight) begin
            reg_d = {newBit, reg_q[W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign parallelOut = reg_q;

endmodule

// File: tb/tb_shift_register.sv
// Directed self-checking bench for shift_register at width 4.
module tb_shift_register;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         sample_en;
    logic         shiftLeft;
    logic         shiftRight;
    logic         newBit;
    logic [W-1:0] parallelIn;
    logic [W-1:0] parallelOut;

    int checks;
    int errors;

    shift_register #(.width(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .sample_en   (sample_en),
        .shiftLeft   (shiftLeft),
        .shiftRight  (shiftRight),
        .newBit      (newBit),
        .parallelIn  (parallelIn),
        .parallelOut (parallelOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] exp);
        checks++;
        assert (parallelOut === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, parallelOut, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic ld, input logic sl,
                         input logic sr, input logic nb, input logic [W-1:0] pin);
        clear      = c;
        sample_en  = ld;
        shiftLeft  = sl;
        shiftRight = sr;
        newBit     = nb;
        parallelIn = pin;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        #1;
        check("reset_initial", 4'b0000);
        edge_step();
        check("reset_held", 4'b0000);
        rst_n = 1'b1;

        // Load 1011, then assert reset mid-cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
        edge_step();
        check("load_1011", 4'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_midcycle", 4'b0000);
        edge_step();
        check("reset_low_blocks_load", 4'b0000);
        rst_n = 1'b1;

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101);
        edge_step();
        check("load_0101", 4'b0101);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            edge_step();
            check("hold_0101", 4'b0101);
        end

        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        edge_step();
        check("shl_nb0", 4'b1010);
        newBit = 1'b1;
        edge_step();
        check("shl_nb1_a", 4'b0101);
        edge_step();
        check("shl_nb1_b", 4'b1011);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101);
        edge_step();
        check("reload_0101_a", 4'b0101);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        edge_step();
        check("shr_nb1", 4'b1010);
        newBit = 1'b0;
        edge_step();
        check("shr_nb0", 4'b0101);

        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        edge_step();
        check("prio_left_over_right", 4'b1011);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1100);
        edge_step();
        check("prio_load_over_shift", 4'b1100);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111);
        edge_step();
        check("prio_clear_over_load", 4'b0000);

        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            edge_step();
            check("clear_held", 4'b0000);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
        edge_step();
        check("clear_release_shr", 4'b1000);
        newBit = 1'b0;
        edge_step();
        check("shr_lsb_discard", 4'b0100);

        // MSB discarded on left shift
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001);
        edge_step();
        check("load_1001", 4'b1001);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        edge_step();
        check("shl_msb_discard", 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
